ring_frc_to_remote_out_arbiter: RTL

- Downstream stage of the force-to-remote controller chain.
- Consumes the three per-destination network-out FIFO streams (xz, x, z) and merges them onto one AXI-Stream master toward the inter-FPGA network port.
- Round-robin arbitration is packet-atomic: a grant is held until the beat carrying last is accepted, and is never switched mid-packet.
- Signals round completion once every source has delivered its final packet of the current force-evaluation iteration.

---
 rtl/ring_frc_to_remote_out_arbiter_pkg.sv | 16 +
 rtl/ring_frc_to_remote_out_arbiter_if.sv | 16 +
 rtl/ring_frc_to_remote_out_arbiter_rr_pick.sv | 28 ++
 rtl/ring_frc_to_remote_out_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ring_frc_to_remote_out_arbiter_pkg.sv
// Shared constants and types for the force-to-remote network-out arbiter.
// Payload width is derived from the AXIS packet struct (payload + node ID + last).
package ring_frc_to_remote_out_arbiter_pkg;

  localparam int NUM_REMOTE_DEST_NODES = 3;
  localparam int NODE_ID_WIDTH         = 3;
  localparam int AXIS_PKT_STRUCT_WIDTH = 512 + NODE_ID_WIDTH + 1;
  localparam int AXIS_PAYLOAD_W        = AXIS_PKT_STRUCT_WIDTH - NODE_ID_WIDTH - 1;
  localparam int BEAT_CNT_W            = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ring_frc_to_remote_out_arbiter_if.sv
// AXI-Stream link from the arbiter toward the inter-FPGA network port.
interface ring_frc_to_remote_out_arbiter_if #(
  parameter int DATA_W = ring_frc_to_remote_out_arbiter_pkg::AXIS_PAYLOAD_W,
  parameter int DEST_W = ring_frc_to_remote_out_arbiter_pkg::NODE_ID_WIDTH
) ();

  logic [DATA_W-1:0] tdata;
  logic [DEST_W-1:0] tdest;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tdest, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tdest, input tlast, input tvalid, output tready);

endinterface

// File: rtl/ring_frc_to_remote_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module ring_frc_out_rr_pick #(
  parameter int NUM_SRC = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic               found
);

  int idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_frc_to_remote_out_arbiter.sv
// Packet-atomic round-robin merge of the xz/x/z network-out FIFOs onto one AXIS master.
// Optional per-source beat counters: define RING_FRC_OUT_ARB_BEAT_CNT_EN.
module ring_frc_to_remote_out_arbiter
  import ring_frc_to_remote_out_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_REMOTE_DEST_NODES,
  parameter int DATA_W  = AXIS_PAYLOAD_W,
  parameter int DEST_W  = NODE_ID_WIDTH,
  parameter int CNT_W   = BEAT_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         i_src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]  i_src_data,
  input  logic [NUM_SRC*DEST_W-1:0]  i_src_dest,
  input  logic [NUM_SRC-1:0]         i_src_last,
  input  logic [NUM_SRC-1:0]         i_src_final,
  output logic [NUM_SRC-1:0]         o_src_pop,
  ring_frc_to_remote_out_arbiter_if.master m_axis,
  output logic [NUM_SRC-1:0]         o_grant_onehot,
  output logic                       o_round_done,
  output logic [NUM_SRC*CNT_W-1:0]   o_dbg_beat_cnt
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  arb_state_e          state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0]  fin_q, fin_d;
  logic                round_done_q, round_done_d;
  logic                tvalid_q, tvalid_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [DEST_W-1:0]   tdest_q, tdest_d;
  logic                tlast_q, tlast_d;

  logic [NUM_SRC-1:0]  pick_grant;
  logic                pick_found;
  logic                slice_can_load;
  logic [NUM_SRC-1:0]  pop;
  logic                pop_any;
  logic [DATA_W-1:0]   sel_data;
  logic [DEST_W-1:0]   sel_dest;
  logic                sel_last;
  logic                sel_final;
  logic [PTR_W-1:0]    sel_idx;
  logic [NUM_SRC-1:0]  fin_next;

  ring_frc_out_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (i_src_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .found (pick_found)
  );

  // Popping only into an empty or draining slice keeps stalled beats stable.
  assign slice_can_load = !tvalid_q || m_axis.tready;
  assign pop            = (state_q == ST_LOCK && slice_can_load) ? (i_src_valid & grant_q) : '0;
  assign pop_any        = |pop;

  always_comb begin
    sel_data  = '0;
    sel_dest  = '0;
    sel_last  = 1'b0;
    sel_final = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_q[k]) begin
        sel_data  = i_src_data[k*DATA_W +: DATA_W];
        sel_dest  = i_src_dest[k*DEST_W +: DEST_W];
        sel_last  = i_src_last[k];
        sel_final = i_src_final[k];
        sel_idx   = PTR_W'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    fin_d        = fin_q;
    round_done_d = 1'b0;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tdest_d      = tdest_q;
    tlast_d      = tlast_q;
    fin_next     = fin_q | grant_q;

    if (slice_can_load) begin
      tvalid_d = pop_any;
      if (pop_any) begin
        tdata_d = sel_data;
        tdest_d = sel_dest;
        tlast_d = sel_last;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_grant;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (pop_any && sel_last) begin
          grant_d  = '0;
          state_d  = ST_IDLE;
          rr_ptr_d = (sel_idx == PTR_W'(NUM_SRC - 1)) ? '0 : sel_idx + 1'b1;
          // The pulse and the clear of the sticky set share one edge.
          if (sel_final) begin
            if (&fin_next) begin
              round_done_d = 1'b1;
              fin_d        = '0;
            end else begin
              fin_d = fin_next;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      fin_q        <= '0;
      round_done_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tdest_q      <= '0;
      tlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      fin_q        <= fin_d;
      round_done_q <= round_done_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tdest_q      <= tdest_d;
      tlast_q      <= tlast_d;
    end
  end

  assign o_src_pop      = pop;
  assign o_grant_onehot = grant_q;
  assign o_round_done   = round_done_q;
  assign m_axis.tvalid  = tvalid_q;
  assign m_axis.tdata   = tdata_q;
  assign m_axis.tdest   = tdest_q;
  assign m_axis.tlast   = tlast_q;

`ifdef RING_FRC_OUT_ARB_BEAT_CNT_EN
  logic [NUM_SRC*CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      cnt_d[k*CNT_W +: CNT_W] = sat_inc(cnt_q[k*CNT_W +: CNT_W], pop[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_dbg_beat_cnt = cnt_q;
`else
  assign o_dbg_beat_cnt = '0;
`endif

endmodule
